// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline register with the ID-stage hazard unit: operand forwarding selects,
// load-use stall, taken-branch flush, and saturating stall/flush debug counters.
module if_id_hazard_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc4,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [4:0]       e_rn,
  input  logic             m_wreg,
  input  logic             m_m2reg,
  input  logic [4:0]       m_rn,
  input  logic             e_branch_taken,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic [3:0]       id_ins_number,
  output logic [1:0]       id_fwda,
  output logic [1:0]       id_fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MLD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [4:0] rs;
  logic [4:0] rt;
  logic       e_alu_rs_hit;
  logic       e_alu_rt_hit;
  logic       m_rs_hit;
  logic       m_rt_hit;
  logic       load_rs_hit;
  logic       load_rt_hit;
  logic       stall;
  logic       flush;
  logic [1:0] fwda_raw;
  logic [1:0] fwdb_raw;

  assign rs = id_inst[25:21];
  assign rt = id_inst[20:16];

  // Register 0 is hard-wired to zero, so a write to it is never a real producer.
  assign e_alu_rs_hit = e_wreg && !e_m2reg && (e_rn != 5'd0) && (e_rn == rs);
  assign e_alu_rt_hit = e_wreg && !e_m2reg && (e_rn != 5'd0) && (e_rn == rt);
  assign m_rs_hit     = m_wreg && (m_rn != 5'd0) && (m_rn == rs);
  assign m_rt_hit     = m_wreg && (m_rn != 5'd0) && (m_rn == rt);

  assign load_rs_hit  = use_rs && (e_rn == rs);
  assign load_rt_hit  = use_rt && (e_rn == rt);

  assign stall = id_valid && e_wreg && e_m2reg && (e_rn != 5'd0) &&
                 (load_rs_hit || load_rt_hit);
  assign flush = e_branch_taken;

  // The younger EXE producer wins over MEM; loads in EXE cannot forward yet.
  always_comb begin
    fwda_raw = FWD_RF;
    if (e_alu_rs_hit) begin
      fwda_raw = FWD_EALU;
    end else if (m_rs_hit) begin
      fwda_raw = m_m2reg ? FWD_MLD : FWD_MALU;
    end
  end

  always_comb begin
    fwdb_raw = FWD_RF;
    if (e_alu_rt_hit) begin
      fwdb_raw = FWD_EALU;
    end else if (m_rt_hit) begin
      fwdb_raw = m_m2reg ? FWD_MLD : FWD_MALU;
    end
  end

  assign id_fwda = stall ? FWD_RF : fwda_raw;
  assign id_fwdb = stall ? FWD_RF : fwdb_raw;

  assign wpcir  = !(stall && !flush);
  assign bubble = stall || flush || !id_valid;

  // Flush beats stall: the stalled instruction is on the wrong path anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_inst       <= NOP_INST;
      id_pc4        <= 32'd0;
      id_valid      <= 1'b0;
      id_ins_number <= 4'd0;
    end else if (flush) begin
      id_inst       <= NOP_INST;
      id_pc4        <= 32'd0;
      id_valid      <= 1'b0;
    end else if (!stall) begin
      id_inst       <= if_inst;
      id_pc4        <= if_pc4;
      id_valid      <= 1'b1;
      id_ins_number <= id_ins_number + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (flush && (flush_cnt != CNT_MAX)) begin
      flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
- IF/ID pipeline register combined with the ID-stage hazard controller.
- Latches the fetched instruction and PC+4, and produces the forwarding selects (id_fwda/id_fwdb) that the ID/EXE register carries into EXE.
- Detects load-use hazards and stalls PC and IF/ID, inserting a bubble into ID/EXE.
- Flushes wrong-path instructions when a branch resolves taken in EXE, and keeps saturating stall/flush event counters for debug.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.
- NOP_INST, 32'h00000000, instruction word injected into IF/ID on flush and reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- if_inst  input  32  fetched instruction.
- if_pc4  input  32  PC+4 of the fetched instruction.
- use_rs  input  1  ID instruction reads rs (from decoder, combinational on id_inst).
- use_rt  input  1  ID instruction reads rt.
- e_wreg  input  1  EXE instruction writes the register file.
- e_m2reg  input  1  EXE instruction is a load.
- e_rn  input  5  EXE destination register.
- m_wreg  input  1  MEM instruction writes the register file.
- m_m2reg  input  1  MEM instruction is a load.
- m_rn  input  5  MEM destination register.
- e_branch_taken  input  1  branch in EXE resolved taken this cycle.
- id_inst  output  32  registered instruction in ID.
- id_pc4  output  32  registered PC+4 in ID.
- id_valid  output  1  ID slot holds a real instruction.
- id_ins_number  output  4  sequence tag of the ID instruction.
- id_fwda  output  2  forward select for operand A.
- id_fwdb  output  2  forward select for operand B.
- wpcir  output  1  PC write enable; 0 means hold PC.
- bubble  output  1  zero all control inputs of the ID/EXE register this cycle.
- stall_cnt  output  CNT_W  saturating count of stall cycles.
- flush_cnt  output  CNT_W  saturating count of flush cycles.

Behaviour:
- rs = id_inst[25:21] and rt = id_inst[20:16].
- Forward encoding:
  - 00: register file.
  - 01: EXE ALU result.
  - 10: MEM ALU result.
  - 11: MEM load data.
- fwda priority (evaluated combinationally):
  - 01 if e_wreg & !e_m2reg & e_rn!=0 & e_rn==rs.
  - Otherwise, if m_wreg & m_rn!=0 & m_rn==rs: 11 when m_m2reg, else 10.
  - Otherwise 00.
- fwdb uses the same rule with rt.
- Register 0 never forwards.
- stall = id_valid & e_wreg & e_m2reg & e_rn!=0 & ((use_rs & e_rn==rs) | (use_rt & e_rn==rt)).
- While stall is high, id_fwda and id_fwdb output 00.
- flush = e_branch_taken. Flush has priority over stall in the same cycle.
- Combinational outputs:
  - wpcir = !(stall & !flush).
  - bubble = stall | flush | !id_valid.
- IF/ID register update on the clock edge, in priority order:
  - rst: id_inst=NOP_INST, id_pc4=0, id_valid=0, id_ins_number=0.
  - flush: id_inst=NOP_INST, id_pc4=0, id_valid=0, id_ins_number unchanged.
  - stall: hold all IF/ID state.
  - Otherwise: load if_inst and if_pc4, id_valid=1, id_ins_number=previous+1 (4-bit wrap, 15 -> 0).
- Load-use latency: exactly one stall cycle per hazard. On the next cycle the load is in MEM, and forwarding select 11 resolves it.
- Counters, on the clock edge:
  - stall_cnt += 1 when stall & !flush.
  - flush_cnt += 1 when flush.
  - Both saturate at all-ones and never wrap.
  - rst clears both.
- Reset asserted mid-stall or mid-flush overrides everything in that cycle; wpcir and bubble are still driven combinationally from their current inputs.
- Reset values: id_inst=NOP_INST, id_pc4=0, id_valid=0, id_ins_number=0, stall_cnt=0, flush_cnt=0. With id_valid=0, bubble=1, stall=0, wpcir=1 and fwda/fwdb follow the rule for rs=rt=0, i.e. 00.

Test Plan:
- Reset, then feed if_inst=32'h00221820 (add $3,$1,$2) with if_pc4=4 -> next cycle id_inst=32'h00221820, id_pc4=4, id_valid=1, id_ins_number=1, bubble=0, wpcir=1.
- ID rs=1; e_wreg=1, e_m2reg=0, e_rn=1; m_wreg=1, m_rn=1 -> id_fwda=01 (EXE wins). With e_wreg=0, m_m2reg=1 -> id_fwda=11. With e_rn=m_rn=0 -> id_fwda=00.
- Load-use: e_wreg=1, e_m2reg=1, e_rn=2, use_rt=1, rt=2 -> wpcir=0, bubble=1 for exactly one cycle, IF/ID held, stall_cnt=1. Next cycle (m_rn=2, m_m2reg=1) -> id_fwdb=11, wpcir=1.
- Stall and e_branch_taken in the same cycle -> wpcir=1, bubble=1, next id_inst=0, id_valid=0, flush_cnt=1, stall_cnt=0.
- 17 consecutive valid loads -> id_ins_number wraps 15 -> 0 -> 1.
- Force 65537 stall cycles (CNT_W=16) -> stall_cnt holds 16'hFFFF. Assert rst mid-stall -> all counters and IF/ID state are at their reset values on the next edge.
